// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the write-through data cache.
// Address layout: [1:0] byte, then word offset, then index, then tag.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  localparam int unsigned NUM_SETS_DEF        = 64;
  localparam int unsigned WORDS_PER_BLOCK_DEF = 4;
  localparam int unsigned OFFSET_W            = $clog2(WORDS_PER_BLOCK_DEF);
  localparam int unsigned INDEX_W             = $clog2(NUM_SETS_DEF);
  localparam int unsigned TAG_W               = 32 - 2 - OFFSET_W - INDEX_W;

  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int unsigned ow);
    return (a >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned ow,
                                             input int unsigned iw);
    return (a >> (ow + 2)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned ow,
                                           input int unsigned iw);
    return a >> (ow + iw + 2);
  endfunction

  // Word address inside the line containing a, at word offset off.
  function automatic logic [31:0] fill_addr(input logic [31:0] a, input logic [31:0] off,
                                            input int unsigned ow);
    return ((a >> (ow + 2)) << (ow + 2)) | (off << 2);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: async read port, synchronous single-word write,
// per-line valid set, all valid bits cleared by reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int unsigned NUM_SETS        = NUM_SETS_DEF,
  parameter  int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK),
  localparam int unsigned IDX_W           = $clog2(NUM_SETS),
  localparam int unsigned TG_W            = 30 - OFF_W - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TG_W-1:0]  rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic             set_valid,
  input  logic [TG_W-1:0]  set_tag
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TG_W-1:0]     tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS*WORDS_PER_BLOCK];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_offset}];

  // Valid bits: cleared on reset, set when a line fill completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset.
  always_ff @(posedge clk) begin
    if (set_valid) tag_q[wr_index] <= set_tag;
    if (wr_en) data_q[{wr_index, wr_offset}] <= wr_data;
  end

endmodule

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Optional statistics counters enabled by defining DCACHE_STATS_EN.
module dcache_wt_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS        = NUM_SETS_DEF,
  parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TG_W  = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_BLOCK - 1);

  state_t           state, state_n;
  logic [OFF_W-1:0] cnt, cnt_n;
  logic             wr_done, wr_done_n;
  logic [31:0]      lat_addr, lat_addr_n, lat_wdata, lat_wdata_n;
  logic [31:0]      mem_addr_n, mem_wdata_n;
  logic             mem_re_n, mem_we_n;

  logic [31:0]      lk_addr, wr_data;
  logic [IDX_W-1:0] lk_index;
  logic [OFF_W-1:0] lk_offset, wr_offset;
  logic [TG_W-1:0]  lk_tag, rd_tag;
  logic             rd_valid, hit, arr_we, set_valid;

  // Lookup uses the live request in IDLE, the latched request otherwise.
  assign lk_addr   = (state == IDLE) ? cpu_addr : lat_addr;
  assign lk_index  = IDX_W'(addr_index(lk_addr, OFF_W, IDX_W));
  assign lk_offset = OFF_W'(addr_offset(lk_addr, OFF_W));
  assign lk_tag    = TG_W'(addr_tag(lk_addr, OFF_W, IDX_W));
  assign hit       = rd_valid && (rd_tag == lk_tag);
  assign wr_offset = (state == FILL) ? cnt : lk_offset;
  assign wr_data   = (state == FILL) ? mem_rdata : lat_wdata;

  dcache_array #(
    .NUM_SETS        (NUM_SETS),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (lk_index),
    .rd_offset (lk_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (cpu_rdata),
    .wr_en     (arr_we),
    .wr_index  (lk_index),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .set_valid (set_valid),
    .set_tag   (lk_tag)
  );

  // Next-state, memory-request and stall logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    wr_done_n   = wr_done;
    lat_addr_n  = lat_addr;
    lat_wdata_n = lat_wdata;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_re_n    = mem_re;
    mem_we_n    = mem_we;
    stall       = 1'b0;
    arr_we      = 1'b0;
    set_valid   = 1'b0;
    case (state)
      IDLE: begin
        wr_done_n = 1'b0;
        if (cpu_we) begin
          if (!wr_done) begin
            stall       = 1'b1;
            state_n     = WRITE;
            lat_addr_n  = {cpu_addr[31:2], 2'b00};
            lat_wdata_n = cpu_wdata;
            mem_we_n    = 1'b1;
            mem_addr_n  = {cpu_addr[31:2], 2'b00};
            mem_wdata_n = cpu_wdata;
          end
        end else if (cpu_re && !hit) begin
          stall      = 1'b1;
          state_n    = FILL;
          cnt_n      = '0;
          lat_addr_n = {cpu_addr[31:2], 2'b00};
          mem_re_n   = 1'b1;
          mem_addr_n = fill_addr(cpu_addr, 32'd0, OFF_W);
        end
      end
      FILL: begin
        stall = 1'b1;
        if (mem_ready) begin
          arr_we = 1'b1;
          if (cnt == LAST_WORD) begin
            set_valid = 1'b1;
            cnt_n     = '0;
            mem_re_n  = 1'b0;
            state_n   = IDLE;
          end else begin
            cnt_n      = cnt + 1'b1;
            mem_addr_n = fill_addr(lat_addr, 32'(cnt) + 32'd1, OFF_W);
          end
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (mem_ready) begin
          arr_we    = hit;
          wr_done_n = 1'b1;
          mem_we_n  = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Controller state and registered memory interface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_done   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wr_done   <= wr_done_n;
      lat_addr  <= lat_addr_n;
      lat_wdata <= lat_wdata_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_re    <= mem_re_n;
      mem_we    <= mem_we_n;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;

  // Saturating hit/miss counters for loads seen in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && cpu_re && !cpu_we) begin
      if (hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else if (miss_count != '1) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

  assign stat_hits   = hit_count;
  assign stat_misses = miss_count;
`endif

endmodule
